// File: rtl/cskip_pkg.sv
// Shared types and default sizing for the sequential carry-skip adder.
package cskip_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cskip_slice.sv
// One SLICE-bit carry-skip group: a ripple core whose carry-out is bypassed
// by the group carry-in whenever every bit position propagates.
module cskip_slice
  import cskip_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] term1,
  input  logic [SLICE-1:0] term2,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             prop
);

  logic [SLICE-1:0] bit_prop;
  logic             ripple_cout;

  always_comb begin
    logic carry;
    bit_prop = term1 ^ term2;
    carry    = cin;
    sum      = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = bit_prop[i] ^ carry;
      carry  = (term1[i] & term2[i]) | (bit_prop[i] & carry);
    end
    ripple_cout = carry;
  end

  assign prop = &bit_prop;
  // When the whole group propagates, cin reaches cout without the ripple path.
  assign cout = prop ? cin : ripple_cout;

endmodule

// File: rtl/cskip_seq_adder.sv
// Sequential carry-skip adder: one SLICE-bit group per cycle through a single
// combinational slice, with valid/ready handshakes on request and result.
module cskip_seq_adder
  import cskip_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int SLICE  = DEF_SLICE,
  localparam int NSLICE = WIDTH / SLICE,
  localparam int CW     = $clog2(NSLICE + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic [CW-1:0]    o_skip_cnt
);

  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_width_check
    $error("cskip_seq_adder: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  state_t           state;
  logic [WIDTH-1:0] term1_q;
  logic [WIDTH-1:0] term2_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    skip_acc;
  logic [CW-1:0]    skip_next;
  int               base;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_prop;
  logic             last_slice;

  assign base       = int'(idx) * SLICE;
  assign slice_a    = term1_q[base +: SLICE];
  assign slice_b    = term2_q[base +: SLICE];
  assign last_slice = (idx == IW'(NSLICE - 1));

  cskip_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .term1 (slice_a),
    .term2 (slice_b),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .prop  (slice_prop)
  );

  // Working sum is built in acc; the visible outputs only change on entering DONE.
  always_comb begin
    acc_next              = acc;
    acc_next[base +: SLICE] = slice_sum;
    skip_next             = skip_acc + CW'(slice_prop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_result   <= '0;
      o_cout     <= 1'b0;
      o_skip_cnt <= '0;
      term1_q    <= '0;
      term2_q    <= '0;
      acc        <= '0;
      carry_q    <= 1'b0;
      idx        <= '0;
      skip_acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            term1_q  <= i_add_term1;
            term2_q  <= i_add_term2;
            carry_q  <= i_cin;
            acc      <= '0;
            idx      <= '0;
            skip_acc <= '0;
            o_ready  <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc      <= acc_next;
          carry_q  <= slice_cout;
          skip_acc <= skip_next;
          if (last_slice) begin
            o_result   <= acc_next;
            o_cout     <= slice_cout;
            o_skip_cnt <= skip_next;
            o_valid    <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
